cvxif_offload_master: RTL and testbench

Core-side initiator of the CORE-V-X-IF coprocessor protocol. Takes offloadable instructions from the core issue stage and drives the X-IF issue handshake. Forwards commit/kill decisions and collects results for core writeback. Tracks up to NbOutstanding in-flight instruction IDs in a scoreboard.

---
 rtl/cvxif_pkg.sv | 78 +++++++
 rtl/cvxif_id_scoreboard.sv | 77 +++++++
 rtl/cvxif_offload_master.sv | 173 +++++++++++++++++
 tb/tb_cvxif_offload_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_pkg.sv
// Shared types for the CORE-V-X-IF offload master: scoreboard entry layout
// and the request/response bundles exchanged with the coprocessor.
package cvxif_pkg;

    localparam int unsigned X_ID_WIDTH  = 4;
    localparam int unsigned X_DATAWIDTH = 32;
    localparam int unsigned X_NUM_RS    = 2;

    typedef enum logic [1:0] {
        ID_FREE      = 2'd0,
        ID_PENDING   = 2'd1,
        ID_COMMITTED = 2'd2
    } id_state_e;

    typedef struct packed {
        id_state_e  state;
        logic [4:0] rd;
        logic       writeback;
    } sb_entry_t;

    typedef enum logic {
        ISS_IDLE  = 1'b0,
        ISS_ISSUE = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic [31:0]                            instr;
        logic [X_NUM_RS-1:0][X_DATAWIDTH-1:0]   rs;
        logic [X_NUM_RS-1:0]                    rs_valid;
        logic [X_ID_WIDTH-1:0]                  id;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_DATAWIDTH-1:0] data;
        logic                   we;
    } x_result_t;

    typedef struct packed {
        logic         x_compressed_valid;
        logic         x_issue_valid;
        x_issue_req_t x_issue_req;
        logic         x_commit_valid;
        x_commit_t    x_commit;
        logic         x_mem_ready;
        x_mem_resp_t  x_mem_resp;
        logic         x_mem_result_valid;
        logic         x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic          x_issue_ready;
        x_issue_resp_t x_issue_resp;
        logic          x_mem_valid;
        logic          x_result_valid;
        x_result_t     x_result;
    } cvxif_resp_t;

    function automatic logic [4:0] instr_rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/cvxif_id_scoreboard.sv
// In-flight ID tracker: per-ID state with rd/writeback, lowest-free allocator
// and two read ports for commit and result lookups.
module cvxif_id_scoreboard import cvxif_pkg::*; #(
    parameter int unsigned NbOutstanding = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hold_valid_i,
    input  logic [X_ID_WIDTH-1:0] hold_id_i,
    output logic                  free_avail_o,
    output logic [X_ID_WIDTH-1:0] free_id_o,
    input  logic                  accept_valid_i,
    input  logic [X_ID_WIDTH-1:0] accept_id_i,
    input  logic [4:0]            accept_rd_i,
    input  logic                  accept_wb_i,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  kill_valid_i,
    input  logic [X_ID_WIDTH-1:0] kill_id_i,
    input  logic                  retire_valid_i,
    input  logic [X_ID_WIDTH-1:0] retire_id_i,
    input  logic [X_ID_WIDTH-1:0] cmt_lookup_id_i,
    output id_state_e             cmt_state_o,
    input  logic [X_ID_WIDTH-1:0] res_lookup_id_i,
    output sb_entry_t             res_entry_o,
    output logic                  busy_o
);

    sb_entry_t entries_q [NbOutstanding];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NbOutstanding); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NbOutstanding); i++) begin
                if (accept_valid_i && accept_id_i == X_ID_WIDTH'(i)) begin
                    entries_q[i] <= '{state: ID_PENDING, rd: accept_rd_i, writeback: accept_wb_i};
                end
                if (commit_valid_i && commit_id_i == X_ID_WIDTH'(i)) begin
                    entries_q[i].state <= ID_COMMITTED;
                end
                if ((kill_valid_i && kill_id_i == X_ID_WIDTH'(i)) ||
                    (retire_valid_i && retire_id_i == X_ID_WIDTH'(i))) begin
                    entries_q[i].state <= ID_FREE;
                end
            end
        end
    end

    // Scan downwards so the lowest eligible index is the last one written.
    always_comb begin
        free_avail_o = 1'b0;
        free_id_o    = '0;
        busy_o       = 1'b0;
        cmt_state_o  = ID_FREE;
        res_entry_o  = '0;
        for (int i = int'(NbOutstanding) - 1; i >= 0; i--) begin
            if (entries_q[i].state == ID_FREE &&
                !(hold_valid_i && hold_id_i == X_ID_WIDTH'(i))) begin
                free_avail_o = 1'b1;
                free_id_o    = X_ID_WIDTH'(i);
            end
            if (entries_q[i].state != ID_FREE) begin
                busy_o = 1'b1;
            end
            if (cmt_lookup_id_i == X_ID_WIDTH'(i)) begin
                cmt_state_o = entries_q[i].state;
            end
            if (res_lookup_id_i == X_ID_WIDTH'(i)) begin
                res_entry_o = entries_q[i];
            end
        end
    end

endmodule

// File: rtl/cvxif_offload_master.sv
// Core-side CORE-V-X-IF initiator: issue FSM, registered commit forwarding and
// result routing to core writeback, backed by the ID scoreboard.
module cvxif_offload_master import cvxif_pkg::*; #(
    parameter int unsigned NbOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   off_valid_i,
    output logic                   off_ready_o,
    input  logic [31:0]            off_instr_i,
    input  logic [X_DATAWIDTH-1:0] off_rs1_i,
    input  logic [X_DATAWIDTH-1:0] off_rs2_i,
    output logic                   off_resp_valid_o,
    output logic                   off_resp_accept_o,
    output logic                   off_resp_writeback_o,
    output logic [X_ID_WIDTH-1:0]  off_resp_id_o,
    input  logic                   commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]  commit_id_i,
    input  logic                   commit_kill_i,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [X_ID_WIDTH-1:0]  wb_id_o,
    output logic [4:0]             wb_rd_o,
    output logic [X_DATAWIDTH-1:0] wb_data_o,
    output logic                   wb_we_o,
    output cvxif_req_t             cvxif_req_o,
    input  cvxif_resp_t            cvxif_resp_i,
    output logic                   err_o,
    output logic                   busy_o
);

    if (NbOutstanding < 1 || NbOutstanding > (1 << X_ID_WIDTH)) begin : g_bad_nb_outstanding
        $error("NbOutstanding must lie in 1..2**X_ID_WIDTH");
    end

    issue_state_e           state_q;
    logic [31:0]            instr_q;
    logic [X_DATAWIDTH-1:0] rs1_q, rs2_q;
    logic [X_ID_WIDTH-1:0]  id_q;
    logic                   resp_valid_q, resp_accept_q, resp_wb_q;
    logic [X_ID_WIDTH-1:0]  resp_id_q;
    logic                   cmt_valid_q, cmt_kill_q;
    logic [X_ID_WIDTH-1:0]  cmt_id_q;
    logic                   err_q, err_d;

    logic                   free_avail;
    logic [X_ID_WIDTH-1:0]  free_id;
    id_state_e              cmt_state;
    sb_entry_t              res_entry;
    logic                   issue_accept, kill_same, res_hit, retire, cmt_ok;

    assign off_ready_o  = (state_q == ISS_IDLE) && free_avail;
    assign issue_accept = (state_q == ISS_ISSUE) && cvxif_resp_i.x_issue_ready &&
                          cvxif_resp_i.x_issue_resp.accept;

    // A kill arriving alongside a result for the same ID takes precedence.
    assign kill_same = commit_valid_i && commit_kill_i && cvxif_resp_i.x_result_valid &&
                       (commit_id_i == cvxif_resp_i.x_result.id);
    assign res_hit   = cvxif_resp_i.x_result_valid && (res_entry.state == ID_COMMITTED) && !kill_same;
    assign retire    = res_hit && wb_ready_i;
    assign cmt_ok    = commit_valid_i &&
                       (cmt_state == ID_PENDING || (kill_same && cmt_state == ID_COMMITTED));

    assign err_d = (commit_valid_i && !cmt_ok) ||
                   (cvxif_resp_i.x_result_valid && wb_ready_i && !res_hit) ||
                   (kill_same && cmt_state == ID_COMMITTED) ||
                   cvxif_resp_i.x_mem_valid;

    cvxif_id_scoreboard #(.NbOutstanding(NbOutstanding)) u_scoreboard (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .hold_valid_i    (state_q == ISS_ISSUE),
        .hold_id_i       (id_q),
        .free_avail_o    (free_avail),
        .free_id_o       (free_id),
        .accept_valid_i  (issue_accept),
        .accept_id_i     (id_q),
        .accept_rd_i     (instr_rd(instr_q)),
        .accept_wb_i     (cvxif_resp_i.x_issue_resp.writeback),
        .commit_valid_i  (cmt_ok && !commit_kill_i),
        .commit_id_i     (commit_id_i),
        .kill_valid_i    (cmt_ok && commit_kill_i),
        .kill_id_i       (commit_id_i),
        .retire_valid_i  (retire),
        .retire_id_i     (cvxif_resp_i.x_result.id),
        .cmt_lookup_id_i (commit_id_i),
        .cmt_state_o     (cmt_state),
        .res_lookup_id_i (cvxif_resp_i.x_result.id),
        .res_entry_o     (res_entry),
        .busy_o          (busy_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ISS_IDLE;
            instr_q       <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            id_q          <= '0;
            resp_valid_q  <= 1'b0;
            resp_accept_q <= 1'b0;
            resp_wb_q     <= 1'b0;
            resp_id_q     <= '0;
        end else begin
            resp_valid_q  <= 1'b0;
            resp_accept_q <= 1'b0;
            resp_wb_q     <= 1'b0;
            resp_id_q     <= '0;
            case (state_q)
                ISS_IDLE: begin
                    if (off_valid_i && off_ready_o) begin
                        instr_q <= off_instr_i;
                        rs1_q   <= off_rs1_i;
                        rs2_q   <= off_rs2_i;
                        id_q    <= free_id;
                        state_q <= ISS_ISSUE;
                    end
                end
                ISS_ISSUE: begin
                    if (cvxif_resp_i.x_issue_ready) begin
                        resp_valid_q  <= 1'b1;
                        resp_accept_q <= cvxif_resp_i.x_issue_resp.accept;
                        resp_wb_q     <= cvxif_resp_i.x_issue_resp.writeback;
                        resp_id_q     <= id_q;
                        state_q       <= ISS_IDLE;
                    end
                end
                default: state_q <= ISS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmt_valid_q <= 1'b0;
            cmt_kill_q  <= 1'b0;
            cmt_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            cmt_valid_q <= cmt_ok;
            cmt_kill_q  <= cmt_ok && commit_kill_i;
            cmt_id_q    <= cmt_ok ? commit_id_i : '0;
            err_q       <= err_d;
        end
    end

    always_comb begin
        cvxif_req_o                      = '0;
        cvxif_req_o.x_issue_valid        = (state_q == ISS_ISSUE);
        cvxif_req_o.x_issue_req.instr    = instr_q;
        cvxif_req_o.x_issue_req.rs[0]    = rs1_q;
        cvxif_req_o.x_issue_req.rs[1]    = rs2_q;
        cvxif_req_o.x_issue_req.rs_valid = (state_q == ISS_ISSUE) ? '1 : '0;
        cvxif_req_o.x_issue_req.id       = id_q;
        cvxif_req_o.x_commit_valid       = cmt_valid_q;
        cvxif_req_o.x_commit.id          = cmt_id_q;
        cvxif_req_o.x_commit.commit_kill = cmt_kill_q;
        cvxif_req_o.x_result_ready       = wb_ready_i;
    end

    assign off_resp_valid_o     = resp_valid_q;
    assign off_resp_accept_o    = resp_accept_q;
    assign off_resp_writeback_o = resp_wb_q;
    assign off_resp_id_o        = resp_id_q;
    assign err_o                = err_q;

    assign wb_valid_o = res_hit;
    assign wb_id_o    = cvxif_resp_i.x_result.id;
    assign wb_rd_o    = res_entry.rd;
    assign wb_data_o  = cvxif_resp_i.x_result.data;
    assign wb_we_o    = cvxif_resp_i.x_result.we & res_entry.writeback;

endmodule

// File: tb/tb_cvxif_offload_master.sv
// Directed bench for cvxif_offload_master: issue, reject, full scoreboard,
// kill, backpressure, error and reset-mid-issue scenarios.
module tb_cvxif_offload_master;
    import cvxif_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   off_valid;
    logic                   off_ready;
    logic [31:0]            off_instr;
    logic [X_DATAWIDTH-1:0] off_rs1, off_rs2;
    logic                   off_resp_valid, off_resp_accept, off_resp_wb;
    logic [X_ID_WIDTH-1:0]  off_resp_id;
    logic                   commit_valid, commit_kill;
    logic [X_ID_WIDTH-1:0]  commit_id;
    logic                   wb_valid, wb_ready, wb_we;
    logic [X_ID_WIDTH-1:0]  wb_id;
    logic [4:0]             wb_rd;
    logic [X_DATAWIDTH-1:0] wb_data;
    cvxif_req_t             req;
    cvxif_resp_t            resp;
    logic                   err, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cvxif_offload_master #(.NbOutstanding(4)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .off_valid_i          (off_valid),
        .off_ready_o          (off_ready),
        .off_instr_i          (off_instr),
        .off_rs1_i            (off_rs1),
        .off_rs2_i            (off_rs2),
        .off_resp_valid_o     (off_resp_valid),
        .off_resp_accept_o    (off_resp_accept),
        .off_resp_writeback_o (off_resp_wb),
        .off_resp_id_o        (off_resp_id),
        .commit_valid_i       (commit_valid),
        .commit_id_i          (commit_id),
        .commit_kill_i        (commit_kill),
        .wb_valid_o           (wb_valid),
        .wb_ready_i           (wb_ready),
        .wb_id_o              (wb_id),
        .wb_rd_o              (wb_rd),
        .wb_data_o            (wb_data),
        .wb_we_o              (wb_we),
        .cvxif_req_o          (req),
        .cvxif_resp_i         (resp),
        .err_o                (err),
        .busy_o               (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rd);
        return {12'h000, 5'd0, 3'd0, rd, 7'b0001011};
    endfunction

    task automatic issue_one(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                             input logic acc, input logic wbk, input logic [3:0] exp_id);
        off_valid = 1'b1;
        off_instr = mk_instr(rd);
        off_rs1   = a;
        off_rs2   = b;
        tick();
        off_valid = 1'b0;
        chk("issue_valid", 64'(req.x_issue_valid), 64'd1);
        chk("issue_id", 64'(req.x_issue_req.id), 64'(exp_id));
        chk("issue_instr", 64'(req.x_issue_req.instr), 64'(mk_instr(rd)));
        chk("issue_rs1", 64'(req.x_issue_req.rs[0]), 64'(a));
        chk("issue_rs2", 64'(req.x_issue_req.rs[1]), 64'(b));
        chk("issue_rs_valid", 64'(req.x_issue_req.rs_valid), 64'd3);
        chk("ready_in_issue", 64'(off_ready), 64'd0);
        resp.x_issue_ready            = 1'b1;
        resp.x_issue_resp.accept      = acc;
        resp.x_issue_resp.writeback   = wbk;
        tick();
        resp.x_issue_ready            = 1'b0;
        resp.x_issue_resp.accept      = 1'b0;
        resp.x_issue_resp.writeback   = 1'b0;
        chk("resp_valid", 64'(off_resp_valid), 64'd1);
        chk("resp_accept", 64'(off_resp_accept), 64'(acc));
        chk("resp_wb", 64'(off_resp_wb), 64'(wbk));
        chk("resp_id", 64'(off_resp_id), 64'(exp_id));
        chk("issue_valid_drop", 64'(req.x_issue_valid), 64'd0);
    endtask

    task automatic drive_commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
    endtask

    task automatic clear_commit();
        commit_valid = 1'b0;
        commit_id    = '0;
        commit_kill  = 1'b0;
    endtask

    task automatic drive_result(input logic [3:0] id, input logic [31:0] data, input logic we,
                                input logic rdy);
        resp.x_result_valid = 1'b1;
        resp.x_result.id    = id;
        resp.x_result.data  = data;
        resp.x_result.we    = we;
        wb_ready            = rdy;
    endtask

    task automatic clear_result();
        resp.x_result_valid = 1'b0;
        resp.x_result       = '0;
        wb_ready            = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        off_valid = 1'b0;
        off_instr = '0;
        off_rs1   = '0;
        off_rs2   = '0;
        wb_ready  = 1'b0;
        resp      = '0;
        clear_commit();

        // Reset state
        tick();
        tick();
        chk("rst_off_ready", 64'(off_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(off_resp_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        n_checks++;
        assert (req === '0) else begin
            n_errors++;
            $error("FAIL rst_req: observed 0x%0h expected 0", req);
        end
        rst = 1'b0;

        // Accepted instruction through commit and writeback
        issue_one(5'd3, 32'd5, 32'd9, 1'b1, 1'b1, 4'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        drive_commit(4'd0, 1'b0);
        tick();
        clear_commit();
        chk("t1_x_commit_valid", 64'(req.x_commit_valid), 64'd1);
        chk("t1_x_commit_id", 64'(req.x_commit.id), 64'd0);
        chk("t1_x_commit_kill", 64'(req.x_commit.commit_kill), 64'd0);
        drive_result(4'd0, 32'd9, 1'b1, 1'b1);
        #1;
        chk("t1_wb_valid", 64'(wb_valid), 64'd1);
        chk("t1_wb_id", 64'(wb_id), 64'd0);
        chk("t1_wb_rd", 64'(wb_rd), 64'd3);
        chk("t1_wb_data", 64'(wb_data), 64'd9);
        chk("t1_wb_we", 64'(wb_we), 64'd1);
        chk("t1_result_ready", 64'(req.x_result_ready), 64'd1);
        tick();
        clear_result();
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_err", 64'(err), 64'd0);

        // Rejected instruction leaves ID 0 free
        issue_one(5'd4, 32'd1, 32'd2, 1'b0, 1'b0, 4'd0);
        chk("t2_busy", 64'(busy), 64'd0);
        chk("t2_no_commit", 64'(req.x_commit_valid), 64'd0);
        issue_one(5'd6, 32'd3, 32'd4, 1'b1, 1'b1, 4'd0);

        // Fill the scoreboard, then free ID 2 via commit + retire
        issue_one(5'd10, 32'h11, 32'h21, 1'b1, 1'b1, 4'd1);
        issue_one(5'd11, 32'h12, 32'h22, 1'b1, 1'b1, 4'd2);
        issue_one(5'd12, 32'h13, 32'h23, 1'b1, 1'b1, 4'd3);
        chk("t3_full_ready", 64'(off_ready), 64'd0);
        drive_commit(4'd2, 1'b0);
        tick();
        clear_commit();
        chk("t3_x_commit_valid", 64'(req.x_commit_valid), 64'd1);
        chk("t3_x_commit_id", 64'(req.x_commit.id), 64'd2);
        drive_result(4'd2, 32'h55, 1'b1, 1'b1);
        #1;
        chk("t3_wb_valid", 64'(wb_valid), 64'd1);
        chk("t3_wb_rd", 64'(wb_rd), 64'd11);
        chk("t3_ready_before", 64'(off_ready), 64'd0);
        tick();
        clear_result();
        chk("t3_ready_after", 64'(off_ready), 64'd1);
        issue_one(5'd13, 32'h14, 32'h24, 1'b1, 1'b1, 4'd2);

        // Kill ID 1, then a stray result for ID 1
        drive_commit(4'd1, 1'b1);
        tick();
        clear_commit();
        chk("t4_x_commit_valid", 64'(req.x_commit_valid), 64'd1);
        chk("t4_x_commit_kill", 64'(req.x_commit.commit_kill), 64'd1);
        chk("t4_x_commit_id", 64'(req.x_commit.id), 64'd1);
        drive_result(4'd1, 32'h77, 1'b1, 1'b1);
        #1;
        chk("t4_wb_valid", 64'(wb_valid), 64'd0);
        tick();
        clear_result();
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_ready", 64'(off_ready), 64'd1);
        tick();
        chk("t4_err_pulse", 64'(err), 64'd0);

        // Backpressure on ID 3
        drive_commit(4'd3, 1'b0);
        tick();
        clear_commit();
        chk("t5_x_commit_valid", 64'(req.x_commit_valid), 64'd1);
        drive_result(4'd3, 32'hABCD1234, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_wb_valid", 64'(wb_valid), 64'd1);
            chk("t5_result_ready", 64'(req.x_result_ready), 64'd0);
            chk("t5_wb_data", 64'(wb_data), 64'hABCD1234);
        end
        wb_ready = 1'b1;
        #1;
        chk("t5_result_ready_hi", 64'(req.x_result_ready), 64'd1);
        tick();
        clear_result();
        chk("t5_err", 64'(err), 64'd0);
        // ID 3 is free now, so a commit to it is a violation
        drive_commit(4'd3, 1'b0);
        tick();
        clear_commit();
        chk("t5_bad_commit_fwd", 64'(req.x_commit_valid), 64'd0);
        chk("t5_bad_commit_err", 64'(err), 64'd1);
        resp.x_mem_valid = 1'b1;
        tick();
        resp.x_mem_valid = 1'b0;
        chk("t5_mem_err", 64'(err), 64'd1);
        chk("t5_mem_ready", 64'(req.x_mem_ready), 64'd0);

        // Reset while an issue is stalled
        off_valid = 1'b1;
        off_instr = mk_instr(5'd7);
        tick();
        off_valid = 1'b0;
        chk("t6_issue_valid", 64'(req.x_issue_valid), 64'd1);
        chk("t6_issue_id", 64'(req.x_issue_req.id), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_issue_valid_rst", 64'(req.x_issue_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ready", 64'(off_ready), 64'd1);
        chk("t6_no_kill", 64'(req.x_commit_valid), 64'd0);

        // Commit and result for different IDs together, then kill vs result on one ID
        issue_one(5'd20, 32'd7, 32'd8, 1'b1, 1'b1, 4'd0);
        issue_one(5'd21, 32'd9, 32'd10, 1'b1, 1'b1, 4'd1);
        drive_commit(4'd0, 1'b0);
        tick();
        drive_commit(4'd1, 1'b0);
        drive_result(4'd0, 32'h1234, 1'b0, 1'b1);
        #1;
        chk("t7_wb_valid", 64'(wb_valid), 64'd1);
        chk("t7_wb_we", 64'(wb_we), 64'd0);
        tick();
        clear_commit();
        clear_result();
        chk("t7_x_commit_valid", 64'(req.x_commit_valid), 64'd1);
        chk("t7_x_commit_id", 64'(req.x_commit.id), 64'd1);
        chk("t7_err", 64'(err), 64'd0);
        drive_commit(4'd1, 1'b1);
        drive_result(4'd1, 32'd5, 1'b1, 1'b1);
        #1;
        chk("t7_kill_wb_valid", 64'(wb_valid), 64'd0);
        tick();
        clear_commit();
        clear_result();
        chk("t7_kill_fwd", 64'(req.x_commit.commit_kill), 64'd1);
        chk("t7_kill_err", 64'(err), 64'd1);
        chk("t7_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
